// File: rtl/multi_btn_debounce.sv
// multi_btn_debounce
// A set of independent pushbutton debouncers that share one sample-tick
// prescaler. For each channel the block synchronises the raw input, applies
// a stable-sample filter, and produces registered one-clock press, release,
// long-press and auto-repeat pulses.
//
// The en input freezes the whole state machine: the prescaler, the tick
// flop, the channel counters, the levels and the pulse flops all hold. The
// pulse and tick outputs are masked while en=0. Masking and holding work
// together: a pulse registered just before en fell is neither dropped nor
// repeated. It appears for exactly one cycle once en returns.
module multi_btn_debounce #(
  parameter int N_CH       = 5,
  parameter int SAMPLE_DIV = 10000,
  parameter int STABLE_CNT = 20,
  parameter int HOLD_CNT   = 500,
  parameter int REPEAT_CNT = 100
) (
  input  logic            TEN_MHZ_CLK,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_press_pulse,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            sample_tick
);

  // Counter widths: one spare bit above $clog2, so that no counter can wrap
  // even when a parameter is an exact power of two.
  localparam int DW = $clog2(SAMPLE_DIV) + 1;
  localparam int SW = $clog2(STABLE_CNT) + 1;
  localparam int HW = $clog2(HOLD_CNT) + 1;
  localparam int RW = $clog2(REPEAT_CNT) + 1;

  localparam logic [DW-1:0] DIV_LAST    = DW'(SAMPLE_DIV - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CNT - 1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_CNT);
  localparam logic [RW-1:0] RPT_LAST    = RW'(REPEAT_CNT - 1);
  localparam bit            RPT_EN      = (REPEAT_CNT > 0);

  logic [DW-1:0] div_q, div_d;
  logic          sample_tick_q, sample_tick_d;
  logic          tick_act;

  // Channel logic acts only in a tick cycle while the block is enabled.
  assign tick_act    = sample_tick_q & en;
  assign sample_tick = tick_act;

  // Prescaler next state: wrap at SAMPLE_DIV-1 and flag the tick. Hold while disabled.
  always_comb begin
    div_d         = div_q;
    sample_tick_d = sample_tick_q;
    if (en) begin
      if (div_q == DIV_LAST) begin
        div_d         = '0;
        sample_tick_d = 1'b1;
      end else begin
        div_d         = div_q + 1'b1;
        sample_tick_d = 1'b0;
      end
    end
  end

  // Prescaler and shared tick registers.
  always_ff @(posedge TEN_MHZ_CLK) begin
    if (!rst_n) begin
      div_q         <= '0;
      sample_tick_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      sample_tick_q <= sample_tick_d;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          rep_q, rep_d;
    logic          flip;

    // Per-channel next state: debounce filter, then the hold and repeat timers.
    always_comb begin
      sync1_d   = btn_in[gi];
      sync2_d   = sync1_q;
      level_d   = level_q;
      stable_d  = stable_q;
      hold_d    = hold_q;
      rpt_d     = rpt_q;
      flip      = 1'b0;
      // Pulses last one enabled cycle. While disabled they are held, so a
      // pending pulse still appears once en returns.
      press_d   = en ? 1'b0 : press_q;
      release_d = en ? 1'b0 : release_q;
      long_d    = en ? 1'b0 : long_q;
      rep_d     = en ? 1'b0 : rep_q;

      if (tick_act) begin
        // Debounce: count consecutive samples that disagree with the level.
        if (sync2_q == level_q) begin
          stable_d = '0;
        end else if (stable_q == STABLE_LAST) begin
          flip      = 1'b1;
          level_d   = ~level_q;
          stable_d  = '0;
          press_d   = ~level_q;
          release_d = level_q;
        end else begin
          stable_d = stable_q + 1'b1;
        end

        // Hold/repeat timing uses the level from before this tick. The press
        // tick therefore never shows a long or repeat pulse. A release tick
        // clears the timers and suppresses any long or repeat pulse due then.
        if (!level_q || flip) begin
          hold_d = '0;
          rpt_d  = '0;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HOLD_LAST) begin
            long_d = 1'b1;
            rpt_d  = '0;
          end
        end else if (RPT_EN) begin
          if (rpt_q == RPT_LAST) begin
            rep_d = 1'b1;
            rpt_d = '0;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end
      end
    end

    // Per-channel registers. Reset discards any partial debounce or hold count.
    always_ff @(posedge TEN_MHZ_CLK) begin
      if (!rst_n) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        level_q   <= 1'b0;
        stable_q  <= '0;
        hold_q    <= '0;
        rpt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        rep_q     <= 1'b0;
      end else begin
        sync1_q   <= sync1_d;
        sync2_q   <= sync2_d;
        level_q   <= level_d;
        stable_q  <= stable_d;
        hold_q    <= hold_d;
        rpt_q     <= rpt_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
        rep_q     <= rep_d;
      end
    end

    assign btn_level[gi]        = level_q;
    assign press_pulse[gi]      = press_q & en;
    assign release_pulse[gi]    = release_q & en;
    assign long_press_pulse[gi] = long_q & en;
    assign repeat_pulse[gi]     = rep_q & en;
  end

endmodule

// File: tb/tb_multi_btn_debounce.sv
// Scoreboard bench for multi_btn_debounce (2 channels, fast timing).
// Stimulus pushes the hand-computed pulse events (cycle, kind, channel).
// A negedge monitor pops one event for every pulse bit it sees asserted.
module tb_multi_btn_debounce;

  localparam int N = 2;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_press_pulse;
  logic [N-1:0] repeat_pulse;
  logic         sample_tick;

  multi_btn_debounce #(
    .N_CH(N), .SAMPLE_DIV(4), .STABLE_CNT(3), .HOLD_CNT(5), .REPEAT_CNT(2)
  ) dut (
    .TEN_MHZ_CLK(clk),
    .rst_n(rst_n),
    .en(en),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_press_pulse(long_press_pulse),
    .repeat_pulse(repeat_pulse),
    .sample_tick(sample_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  r_base   = 0;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;
  localparam int K_REP   = 3;

  function automatic string kname(input int k);
    case (k)
      K_PRESS: return "press";
      K_REL:   return "release";
      K_LONG:  return "long";
      default: return "repeat";
    endcase
  endfunction

  // Queue an expected pulse at an offset from the latest reset release.
  task automatic expect_ev(input int kind, input int ch, input int off);
    ev_t e;
    e.cyc  = r_base + off;
    e.kind = kind;
    e.ch   = ch;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s = 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic on_pulse(input int k, input int c);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_pulse: got %s ch%0d at cycle %0d, required none", kname(k), c, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.kind != k || e.ch != c) begin
        failures++;
        $display("FAIL pulse: got %s ch%0d at cycle %0d, required %s ch%0d at cycle %0d",
                 kname(k), c, cyc, kname(e.kind), e.ch, e.cyc);
      end else begin
        $display("ok   pulse %s ch%0d at cycle %0d", kname(k), c, cyc);
      end
    end
  endtask

  // Monitor: each asserted pulse bit is one transaction to match.
  logic [3:0][N-1:0] pv;
  always @(negedge clk) begin
    pv = {repeat_pulse, long_press_pulse, release_pulse, press_pulse};
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < N; c++) begin
        if (pv[k][c] === 1'b1) on_pulse(k, c);
      end
    end
  end

  // Advance to #1 after the edge that brings cyc to r_base+off.
  task automatic wait_to(input int off);
    while (cyc < r_base + off) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    chk("reset_outputs",
        32'({btn_level, press_pulse, release_pulse, long_press_pulse, repeat_pulse, sample_tick}),
        32'd0);
    rst_n  = 1'b1;
    r_base = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    btn_in = '0;
    @(posedge clk);
    #1;

    // 1. Reset with both buttons held: simultaneous presses, then releases.
    btn_in = 2'b11;
    do_reset(3);
    expect_ev(K_PRESS, 0, 13);
    expect_ev(K_PRESS, 1, 13);
    wait_to(4);
    chk("tick_first", 32'(sample_tick), 32'd1);
    wait_to(5);
    chk("tick_one_wide", 32'(sample_tick), 32'd0);
    wait_to(12);
    chk("s1_level_before", 32'(btn_level), 32'd0);
    wait_to(14);
    chk("s1_level_pressed", 32'(btn_level), 32'd3);
    wait_to(20);
    btn_in = 2'b00;
    // Hold count reaches 4 of 5 before release: no long press.
    expect_ev(K_REL, 0, 33);
    expect_ev(K_REL, 1, 33);
    wait_to(34);
    chk("s1_level_released", 32'(btn_level), 32'd0);
    wait_to(45);

    // 2. Bounce on channel 0 with 5-cycle half period: never accepted.
    btn_in = 2'b00;
    do_reset(2);
    for (int i = 0; i < 12; i++) begin
      wait_to(10 + 5 * i);
      btn_in[0] = (i % 2 == 0);
      chk("s2_bounce_level", 32'(btn_level[0]), 32'd0);
    end
    wait_to(100);
    chk("s2_final_level", 32'(btn_level), 32'd0);

    // 3. Clean 40-cycle press on channel 0.
    do_reset(2);
    wait_to(10);
    btn_in[0] = 1'b1;
    expect_ev(K_PRESS, 0, 21);
    expect_ev(K_LONG,  0, 41);
    expect_ev(K_REP,   0, 49);
    expect_ev(K_REP,   0, 57);
    wait_to(22);
    chk("s3_level_high", 32'(btn_level), 32'd1);
    wait_to(50);
    btn_in[0] = 1'b0;
    expect_ev(K_REL, 0, 61);
    wait_to(62);
    chk("s3_level_low", 32'(btn_level), 32'd0);
    wait_to(80);

    // 4. Long press and repeat on channel 1, then release.
    btn_in = 2'b00;
    do_reset(2);
    wait_to(10);
    btn_in[1] = 1'b1;
    expect_ev(K_PRESS, 1, 21);
    expect_ev(K_LONG,  1, 41);
    expect_ev(K_REP,   1, 49);
    expect_ev(K_REP,   1, 57);
    expect_ev(K_REP,   1, 65);
    expect_ev(K_REP,   1, 73);
    expect_ev(K_REL,   1, 81);
    wait_to(42);
    chk("s4_level_held", 32'(btn_level), 32'd2);
    wait_to(70);
    btn_in[1] = 1'b0;
    wait_to(82);
    chk("s4_level_released", 32'(btn_level), 32'd0);
    wait_to(110);

    // 5. en=0 for 30 cycles with stable count at 1.
    btn_in = 2'b00;
    do_reset(2);
    wait_to(10);
    btn_in[0] = 1'b1;
    wait_to(14);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_to(20 + 8 * i);
      chk("s5_frozen_tick", 32'(sample_tick), 32'd0);
      chk("s5_frozen_level", 32'(btn_level), 32'd0);
    end
    wait_to(44);
    en = 1'b1;
    expect_ev(K_PRESS, 0, 51);
    wait_to(50);
    chk("s5_level_before", 32'(btn_level), 32'd0);
    wait_to(52);
    chk("s5_level_after", 32'(btn_level), 32'd1);
    wait_to(60);

    // 6. One-cycle reset during a repeat sequence on channel 1.
    btn_in = 2'b00;
    do_reset(2);
    wait_to(10);
    btn_in[1] = 1'b1;
    expect_ev(K_PRESS, 1, 21);
    expect_ev(K_LONG,  1, 41);
    expect_ev(K_REP,   1, 49);
    expect_ev(K_REP,   1, 57);
    wait_to(59);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("s6_reset_level", 32'(btn_level), 32'd0);
    chk("s6_reset_pulses",
        32'({press_pulse, release_pulse, long_press_pulse, repeat_pulse}), 32'd0);
    rst_n  = 1'b1;
    r_base = cyc;
    expect_ev(K_PRESS, 1, 13);
    wait_to(12);
    chk("s6_level_redebounce", 32'(btn_level), 32'd0);
    wait_to(14);
    chk("s6_level_repressed", 32'(btn_level), 32'd2);
    wait_to(25);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses: got %0d unmatched expected events, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_btn_debounce.md
Name: multi_btn_debounce

Overview:
Parametrised, multi-channel successor to the single-button debouncer. It runs N_CH independent channels from one shared sample-tick prescaler. Each channel synchronises its raw input and requires STABLE_CNT consecutive agreeing samples before changing level. It emits one-clock press/release pulses plus long-press and auto-repeat pulses. It sits between the board pushbuttons and the calculator input FSM, replacing per-button clock dividers.

Parameters:
N_CH, 5, number of independent button channels (1..16)
SAMPLE_DIV, 10000, TEN_MHZ_CLK cycles per sample tick (1 kHz at 10 MHz); must be >= 2
STABLE_CNT, 20, consecutive disagreeing samples required to flip level (>= 1)
HOLD_CNT, 500, ticks of continuous press before long_press pulse (>= 1)
REPEAT_CNT, 100, ticks between repeat pulses after long press; 0 = repeat disabled

Ports:
TEN_MHZ_CLK  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
en  input  1  1 = run; 0 = freeze prescaler and all channel counters
btn_in  input  N_CH  raw asynchronous button inputs, active-high
btn_level  output  N_CH  debounced level per channel
press_pulse  output  N_CH  one-cycle pulse on debounced 0->1
release_pulse  output  N_CH  one-cycle pulse on debounced 1->0
long_press_pulse  output  N_CH  one-cycle pulse when hold reaches HOLD_CNT ticks
repeat_pulse  output  N_CH  one-cycle pulse every REPEAT_CNT ticks after long press
sample_tick  output  1  registered shared tick, for debug/verification

Behaviour:
- Reset (rst_n=0 at a clock edge): prescaler, sync flops, stable/hold counters, btn_level and all pulse outputs go to 0. Reset is sampled only on TEN_MHZ_CLK. Reset mid-debounce discards partial counts.
- Synchroniser: a 2-flop chain per channel, reset to 0. sync[i] lags btn_in by 2 cycles.
- Prescaler: counts 0..SAMPLE_DIV-1 when en=1, then wraps. sample_tick is registered high for exactly one cycle when the count wraps. With en=0 the count holds and sample_tick=0.
- Channel debounce, evaluated only in a tick cycle:
  - If sync[i]==btn_level[i]: stable_cnt clears to 0.
  - Else, if stable_cnt==STABLE_CNT-1: btn_level toggles, stable_cnt clears, and the matching press/release pulse is high in the next cycle.
  - Else: stable_cnt increments.
  - Glitches shorter than STABLE_CNT ticks never change level.
- Latency: from a clean input edge to the pulse is 2 sync cycles plus STABLE_CNT ticks, ±1 tick of phase, plus 1 cycle.
- Hold/repeat, evaluated only in tick cycles:
  - hold_cnt clears whenever btn_level=0 and increments while btn_level=1, saturating at HOLD_CNT.
  - When hold_cnt reaches HOLD_CNT, long_press_pulse fires once and rpt_cnt clears.
  - After that, if REPEAT_CNT>0, rpt_cnt counts ticks. Each time it reaches REPEAT_CNT, repeat_pulse fires and rpt_cnt clears.
  - Release clears hold_cnt and rpt_cnt in the same tick that fires release_pulse. No long/repeat pulse may follow a release.
- Pulses: all pulse outputs are registered and exactly one clock wide. At most one of press/release fires per channel per cycle. Long_press and repeat never coincide with press. Channels are fully independent, so simultaneous events on different channels produce simultaneous pulses.
- en=0 mid-count: all counters and levels hold, and pulses are 0. Counting resumes at en=1 with no lost or duplicated pulse.
- Counter widths: $clog2 of the parameter plus 1, with no overflow at maximum parameter values.
- Expected RTL size: roughly 150-250 lines (generate loop per channel).

Test Plan:
(All scenarios use SAMPLE_DIV=4, STABLE_CNT=3, HOLD_CNT=5, REPEAT_CNT=2, N_CH=2.)
1. Reset/idle: rst_n=0 for 3 cycles with btn_in=2'b11, then release reset -> all outputs 0 at reset. The first press_pulse on both channels comes 3 ticks after the sync delay (≈14 cycles), both in the same cycle.
2. Bounce reject: toggle btn_in[0] every 5 cycles for 60 cycles, then hold 0 -> btn_level[0] stays 0 and press_pulse[0] never asserts.
3. Clean press/release: hold btn_in[0]=1 for 40 cycles, then 0 -> exactly one press_pulse[0] and one release_pulse[0], each 1 cycle wide, each ≤ 2+4*3+4+1 cycles after its edge.
4. Long press/repeat: hold btn_in[1]=1 -> long_press_pulse[1] 5 ticks after press_pulse[1], then repeat_pulse[1] every 8 cycles. On release, release_pulse[1] fires and no further repeat pulses follow.
5. en freeze: drop en=0 mid-debounce (stable_cnt=1) for 30 cycles, then restore -> no tick and no pulses while en=0. The press completes 2 ticks after en returns.
6. Reset mid-hold: assert rst_n=0 for 1 cycle during a repeat sequence -> btn_level=0 and pulses cease at once. The channel re-debounces and a fresh press_pulse fires.
